rmt_ingress_arbiter: RTL and testbench
======================================

// Module: rmt_ingress_arbiter
// PURPOSE
//  Packet-granular round-robin arbiter that merges S_COUNT AXI-Stream sources (host TX queues, loopback)
//  onto the single ingress of the rmt match-action classifier. A grant is held from first beat to tlast,
//  so frames never interleave. A registered output stage decouples rmt backpressure from source timing.
//  m_axis_tid tags each beat with its source port. cfg_enable masks ports out of arbitration.
// PARAMETERS
//  S_COUNT     4               number of source ports (>=2)
//  DATA_WIDTH  512             tdata width per port
//  KEEP_WIDTH  DATA_WIDTH/8    tkeep width per port
//  USER_WIDTH  1               tuser width per port
//  ID_WIDTH    $clog2(S_COUNT) width of m_axis_tid / grant_idx
// PORTS
//  clk            in   1                     clock, all logic rising-edge
//  rst            in   1                     asynchronous, active-high reset
//  s_axis_tdata   in   S_COUNT*DATA_WIDTH    per-port data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//  s_axis_tkeep   in   S_COUNT*KEEP_WIDTH    per-port byte enables
//  s_axis_tvalid  in   S_COUNT               per-port valid
//  s_axis_tready  out  S_COUNT               per-port ready; only the granted bit may be 1
//  s_axis_tlast   in   S_COUNT               per-port end of frame
//  s_axis_tuser   in   S_COUNT*USER_WIDTH    per-port sideband
//  m_axis_tdata   out  DATA_WIDTH            merged stream to rmt
//  m_axis_tkeep   out  KEEP_WIDTH
//  m_axis_tvalid  out  1
//  m_axis_tready  in   1
//  m_axis_tlast   out  1
//  m_axis_tuser   out  USER_WIDTH
//  m_axis_tid     out  ID_WIDTH              source port of current beat
//  cfg_enable     in   S_COUNT               1 = port eligible for new grants
//  busy           out  1                     grant held (frame in progress)
//  grant_idx      out  ID_WIDTH              currently/last granted port
// BEHAVIOUR
//  Reset (async, rst=1): m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata/tkeep/tuser/tid=0, s_axis_tready=0,
//   busy=0, grant_idx=0, RR pointer last=S_COUNT-1 so port 0 has top priority on the first grant.
//  FSM: IDLE, GRANT.
//   IDLE: req = s_axis_tvalid & cfg_enable. If req!=0, pick the first set bit scanning last+1, last+2, ...
//    mod S_COUNT; register grant_idx, busy=1, go to GRANT at next edge. No beat is accepted in IDLE.
//   GRANT: s_axis_tready[grant_idx] = out_ready, where out_ready = !m_axis_tvalid || m_axis_tready;
//    all other ready bits 0. Beat accepted when s_axis_tvalid[g] && s_axis_tready[g].
//    Accepted beat with tlast=1: last<=grant_idx, busy<=0, back to IDLE at same edge.
//  Arbitration latency: 1 cycle from request to s_axis_tready; 1 idle input cycle between frames.
//  Output register: on accepted beat load data/keep/user/last/tid=grant_idx, m_axis_tvalid<=1;
//   else if m_axis_tready, m_axis_tvalid<=0. Input->output latency 1 cycle; full rate while
//   m_axis_tready=1. Output fields hold stable while tvalid=1 and tready=0 (AXIS rule).
//  Boundary conditions:
//   - granted source drops tvalid mid-frame: grant held indefinitely, no timeout, no other port served.
//   - cfg_enable[g] cleared mid-frame: current frame finishes; port excluded from next arbitration.
//   - cfg_enable all zero: stays IDLE, no ready asserted.
//   - single-beat frame (tlast on first beat): grant released at that same edge.
//   - only one requester: re-granted after each frame with 1-cycle gap.
//   - pointer wrap: last=S_COUNT-1 scans from port 0.
//   - reset mid-frame: output beat discarded, frame truncated; rmt is reset by the same rst.
//   - s_axis_tready never depends combinationally on s_axis_tvalid.
// TESTING
//  1. S_COUNT=4, ports 0-3 each hold a 3-beat frame at t0 -> output order 0,1,2,3, tid matches, no interleave.
//  2. Port 2 sends back-to-back 1-beat frames, port 0 idle until port 2 frame #1 done, then requests
//     -> next grant goes to port 0 (pointer=3 wraps to 0), then port 2 again.
//  3. m_axis_tready toggled 1/0 every cycle during a 4-beat frame -> all 4 beats delivered in order,
//     each held stable while stalled, s_axis_tready follows out_ready.
//  4. cfg_enable=4'b1011, all ports request -> port 2 never granted. Clear bit 0 mid-frame on port 0
//     -> frame completes, then ports 1,3 only.
//  5. Assert rst mid-frame on beat 2 of 5 -> m_axis_tvalid, busy, s_axis_tready go 0 asynchronously;
//     after release, port 0 wins with all ports requesting.

Source files
------------

// File: rtl/rmt_ingress_arbiter.sv
// rmt_ingress_arbiter: packet-granular round-robin merge of S_COUNT AXI-Stream sources onto the
// single rmt classifier ingress, with a registered output stage and per-beat source tagging.
module rmt_ingress_arbiter #(
    parameter int S_COUNT    = 4,
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH/8,
    parameter int USER_WIDTH = 1,
    parameter int ID_WIDTH   = $clog2(S_COUNT)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [S_COUNT*DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [S_COUNT*KEEP_WIDTH-1:0]   s_axis_tkeep,
    input  logic [S_COUNT-1:0]              s_axis_tvalid,
    output logic [S_COUNT-1:0]              s_axis_tready,
    input  logic [S_COUNT-1:0]              s_axis_tlast,
    input  logic [S_COUNT*USER_WIDTH-1:0]   s_axis_tuser,
    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]           m_axis_tkeep,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,
    output logic [USER_WIDTH-1:0]           m_axis_tuser,
    output logic [ID_WIDTH-1:0]             m_axis_tid,
    input  logic [S_COUNT-1:0]              cfg_enable,
    output logic                            busy,
    output logic [ID_WIDTH-1:0]             grant_idx
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]            state;
    logic [ID_WIDTH-1:0]   last_ptr;
    logic [S_COUNT-1:0]    req;
    logic                  found;
    logic [ID_WIDTH-1:0]   next_grant;
    logic [ID_WIDTH-1:0]   cand_idx;
    int                    cand;
    logic                  out_ready;
    logic                  accept;
    logic                  sel_valid;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [KEEP_WIDTH-1:0] sel_keep;
    logic [USER_WIDTH-1:0] sel_user;

    assign req       = s_axis_tvalid & cfg_enable;
    assign out_ready = !m_axis_tvalid || m_axis_tready;
    assign busy      = (state == GRANT);
    assign accept    = busy && sel_valid && out_ready;

    // Rotating scan starting just after the last port to complete a frame.
    always_comb begin
        found      = 1'b0;
        next_grant = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int k = 1; k <= S_COUNT; k++) begin
            cand     = (int'(last_ptr) + k) % S_COUNT;
            cand_idx = ID_WIDTH'(cand);
            if (!found && req[cand_idx]) begin
                found      = 1'b1;
                next_grant = cand_idx;
            end
        end
    end

    // Ready is a function of the grant and output stage only, never of source valid.
    always_comb begin
        sel_valid     = 1'b0;
        sel_last      = 1'b0;
        sel_data      = '0;
        sel_keep      = '0;
        sel_user      = '0;
        s_axis_tready = '0;
        for (int i = 0; i < S_COUNT; i++) begin
            if (grant_idx == ID_WIDTH'(i)) begin
                sel_valid        = s_axis_tvalid[i];
                sel_last         = s_axis_tlast[i];
                sel_data         = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_keep         = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
                sel_user         = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
                s_axis_tready[i] = busy && out_ready;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            grant_idx     <= '0;
            last_ptr      <= ID_WIDTH'(S_COUNT-1);
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tid    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_idx <= next_grant;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (accept && sel_last) begin
                        last_ptr <= grant_idx;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (accept) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= sel_data;
                m_axis_tkeep  <= sel_keep;
                m_axis_tuser  <= sel_user;
                m_axis_tlast  <= sel_last;
                m_axis_tid    <= grant_idx;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rmt_ingress_arbiter.sv
// Testbench for rmt_ingress_arbiter: queue-based source/sink reference model with randomized
// data, frame lengths, backpressure and mid-frame source pauses, plus directed arbitration scenarios.
module tb_rmt_ingress_arbiter;

    localparam int S  = 4;
    localparam int DW = 32;
    localparam int KW = 4;
    localparam int UW = 1;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [S*DW-1:0]   s_axis_tdata;
    logic [S*KW-1:0]   s_axis_tkeep;
    logic [S-1:0]      s_axis_tvalid;
    logic [S-1:0]      s_axis_tready;
    logic [S-1:0]      s_axis_tlast;
    logic [S*UW-1:0]   s_axis_tuser;
    logic [DW-1:0]     m_axis_tdata;
    logic [KW-1:0]     m_axis_tkeep;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              m_axis_tlast;
    logic [UW-1:0]     m_axis_tuser;
    logic [IW-1:0]     m_axis_tid;
    logic [S-1:0]      cfg_enable;
    logic              busy;
    logic [IW-1:0]     grant_idx;

    always #5 clk = ~clk;

    rmt_ingress_arbiter #(
        .S_COUNT(S), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW), .ID_WIDTH(IW)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .m_axis_tid(m_axis_tid), .cfg_enable(cfg_enable), .busy(busy), .grant_idx(grant_idx)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    beat_t             src_q [S][$];
    logic [39:0]       exp_q [$];
    int                tid_order [$];
    int                acc_beats [S];
    int                frames_done [S];
    logic [S-1:0]      mid;
    logic              out_sof;
    logic              m_busy;
    logic              m_ovalid;
    int                m_grant;
    int                m_last;
    int                tready_mode;
    int                pause_pct;
    logic              tog;
    int                errors = 0;
    int                checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    // Round-robin rule: first requester after the last completed port, wrapping.
    function automatic int pick(input logic [S-1:0] r, input int last);
        int p;
        for (int k = 1; k <= S; k++) begin
            p = (last + k) % S;
            if (r[p[IW-1:0]]) return p;
        end
        return -1;
    endfunction

    function automatic int pending();
        int n = exp_q.size();
        for (int i = 0; i < S; i++) n += src_q[i].size();
        return n;
    endfunction

    function automatic int count_tid(input int v, input int from);
        int n = 0;
        for (int i = from; i < tid_order.size(); i++) if (tid_order[i] == v) n++;
        return n;
    endfunction

    task automatic load_frame(input int p, input int len);
        beat_t b;
        for (int j = 0; j < len; j++) begin
            b.data = DW'($urandom);
            b.keep = KW'($urandom_range(1, 15));
            b.user = UW'($urandom_range(0, 1));
            b.last = (j == len - 1);
            src_q[p].push_back(b);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < S; i++) src_q[i].delete();
        exp_q.delete();
        mid      = '0;
        out_sof  = 1'b1;
        m_busy   = 1'b0;
        m_ovalid = 1'b0;
        m_grant  = 0;
        m_last   = S - 1;
    endtask

    // One clock: drive at posedge+1, check and advance the model at negedge.
    task automatic tick();
        logic [S-1:0] vld;
        logic [S-1:0] exp_rdy;
        logic         rdy;
        logic         out_rdy;
        logic         acc;
        logic [39:0]  pres;
        beat_t        b;
        int           g;
        for (int i = 0; i < S; i++) begin
            vld[i] = (src_q[i].size() > 0) && !(mid[i] && ($urandom_range(0, 99) < pause_pct));
            if (vld[i]) b = src_q[i][0];
            else b = '{data: DW'($urandom), keep: '0, user: '0, last: 1'b0};
            s_axis_tdata[i*DW +: DW] = b.data;
            s_axis_tkeep[i*KW +: KW] = b.keep;
            s_axis_tuser[i*UW +: UW] = b.user;
            s_axis_tlast[i]          = b.last;
        end
        s_axis_tvalid = vld;
        tog = ~tog;
        case (tready_mode)
            0:       rdy = 1'b1;
            1:       rdy = 1'($urandom_range(0, 1));
            default: rdy = tog;
        endcase
        m_axis_tready = rdy;
        @(negedge clk);
        out_rdy = !m_ovalid || rdy;
        exp_rdy = '0;
        if (m_busy && out_rdy) exp_rdy[m_grant[IW-1:0]] = 1'b1;
        check("s_tready", 64'(s_axis_tready), 64'(exp_rdy));
        check("m_tvalid", 64'(m_axis_tvalid), 64'(m_ovalid));
        check("busy", 64'(busy), 64'(m_busy));
        if (m_busy) check("grant_idx", 64'(grant_idx), 64'(m_grant[IW-1:0]));
        if (m_axis_tvalid) begin
            if (exp_q.size() == 0) begin
                check("out_unexpected_beat", 64'(m_axis_tvalid), 64'd0);
            end else begin
                pres = {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast, m_axis_tid};
                check("out_beat", 64'(pres), 64'(exp_q[0]));
                if (rdy) begin
                    void'(exp_q.pop_front());
                    if (out_sof) tid_order.push_back(int'(m_axis_tid));
                    out_sof = m_axis_tlast;
                end
            end
        end
        acc = m_busy && vld[m_grant[IW-1:0]] && out_rdy;
        if (acc) begin
            b = src_q[m_grant].pop_front();
            exp_q.push_back({b, m_grant[IW-1:0]});
            acc_beats[m_grant]++;
            mid[m_grant[IW-1:0]] = !b.last;
            if (b.last) begin
                frames_done[m_grant]++;
                m_busy = 1'b0;
                m_last = m_grant;
            end
        end else if (!m_busy) begin
            g = pick(vld & cfg_enable, m_last);
            if (g >= 0) begin
                m_busy  = 1'b1;
                m_grant = g;
            end
        end
        m_ovalid = acc ? 1'b1 : (rdy ? 1'b0 : m_ovalid);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((pending() > 0 || m_busy || m_ovalid) && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_drain_left"}, 64'(pending()), 64'd0);
    endtask

    initial begin
        int start;
        int sw;
        int base;
        int n;
        rst = 1'b1;
        s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tuser = '0; s_axis_tlast = '0;
        s_axis_tvalid = '1;
        m_axis_tready = 1'b1;
        cfg_enable = '1;
        tog = 1'b0;
        tready_mode = 0;
        pause_pct = 0;
        for (int i = 0; i < S; i++) begin acc_beats[i] = 0; frames_done[i] = 0; end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_m_tlast", 64'(m_axis_tlast), 64'd0);
        check("rst_m_fields", 64'({m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tid}), 64'd0);
        check("rst_s_tready", 64'(s_axis_tready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_grant_idx", 64'(grant_idx), 64'd0);
        s_axis_tvalid = '0;
        rst = 1'b0;

        // All four ports hold a 3-beat frame: served 0,1,2,3 with no interleave.
        start = tid_order.size();
        for (int p = 0; p < S; p++) load_frame(p, 3);
        drain("rr4", 200);
        check("rr4_nframes", 64'(tid_order.size() - start), 64'd4);
        for (int k = 0; k < 4 && start + k < tid_order.size(); k++)
            check("rr4_order", 64'(tid_order[start + k]), 64'(k));

        // Port 2 single-beat frames; port 0 arrives after the first one completes.
        start = tid_order.size();
        base = frames_done[2];
        for (int j = 0; j < 3; j++) load_frame(2, 1);
        n = 0;
        while (frames_done[2] < base + 1 && n < 50) begin tick(); n++; end
        check("wrap_setup", 64'(frames_done[2] - base), 64'd1);
        load_frame(0, 2);
        drain("wrap", 200);
        check("wrap_nframes", 64'(tid_order.size() - start), 64'd4);
        if (tid_order.size() - start >= 4) begin
            check("wrap_order0", 64'(tid_order[start]), 64'd2);
            check("wrap_order1", 64'(tid_order[start + 1]), 64'd0);
            check("wrap_order2", 64'(tid_order[start + 2]), 64'd2);
            check("wrap_order3", 64'(tid_order[start + 3]), 64'd2);
        end

        // Output backpressure toggling every cycle during a 4-beat frame.
        start = tid_order.size();
        tready_mode = 2;
        load_frame(1, 4);
        drain("stall", 200);
        check("stall_nframes", 64'(tid_order.size() - start), 64'd1);
        if (tid_order.size() > start) check("stall_tid", 64'(tid_order[start]), 64'd1);

        // Port 2 masked; port 0 masked mid-frame, its frame still completes.
        start = tid_order.size();
        tready_mode = 1;
        pause_pct = 20;
        cfg_enable = 4'b1011;
        for (int p = 0; p < S; p++) begin load_frame(p, 2); load_frame(p, 2); end
        n = 0;
        while (!mid[0] && n < 300) begin tick(); n++; end
        check("mask_setup_mid0", 64'(mid[0]), 64'd1);
        cfg_enable = 4'b1010;
        sw = tid_order.size();
        n = 0;
        while ((src_q[1].size() > 0 || src_q[3].size() > 0 || m_busy || exp_q.size() > 0) && n < 400) begin
            tick();
            n++;
        end
        check("mask_p13_left", 64'(src_q[1].size() + src_q[3].size()), 64'd0);
        check("mask_p2_never", 64'(count_tid(2, start)), 64'd0);
        check("mask_p2_left", 64'(src_q[2].size()), 64'd4);
        check("mask_p0_after_clear", 64'(count_tid(0, sw + 1)), 64'd0);
        cfg_enable = '0;
        n = tid_order.size();
        repeat (8) tick();
        check("en0_no_frames", 64'(tid_order.size()), 64'(n));
        cfg_enable = '1;
        drain("mask", 400);

        // Randomized rounds across all ports.
        for (int r = 0; r < 6; r++) begin
            tready_mode = (r % 2 == 0) ? 1 : 0;
            pause_pct = $urandom_range(0, 40);
            for (int p = 0; p < S; p++)
                repeat ($urandom_range(0, 3)) load_frame(p, $urandom_range(1, 5));
            drain("rand", 2000);
        end

        // Reset asserted on beat 2 of a 5-beat frame.
        tready_mode = 0;
        pause_pct = 0;
        base = acc_beats[0];
        load_frame(0, 5);
        n = 0;
        while (acc_beats[0] < base + 2 && n < 50) begin tick(); n++; end
        check("rstmid_setup", 64'(acc_beats[0] - base), 64'd2);
        rst = 1'b1;
        #1;
        check("rstmid_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rstmid_busy", 64'(busy), 64'd0);
        check("rstmid_s_tready", 64'(s_axis_tready), 64'd0);
        check("rstmid_grant_idx", 64'(grant_idx), 64'd0);
        model_reset();
        s_axis_tvalid = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        start = tid_order.size();
        for (int p = 0; p < S; p++) load_frame(p, 1);
        drain("post_rst", 200);
        check("post_rst_nframes", 64'(tid_order.size() - start), 64'd4);
        for (int k = 0; k < 4 && start + k < tid_order.size(); k++)
            check("post_rst_order", 64'(tid_order[start + k]), 64'(k));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
